bcd_to_bin: RTL and testbench
=============================

Name: bcd_to_bin

Overview:
- Sequential BCD-to-binary converter using reverse double-dabble (shift right, then subtract 3 from any digit ≥ 8).
- Sits on the input side of the SPI PMOD path: it turns operator- or host-entered decimal digits back into the binary byte that the binary-to-BCD display path renders.
- Start/done handshake; one conversion every BIN_W+1 cycles.

Parameters:
- DIGITS, 3, number of packed BCD digits on bcd_in (digit 0 = ones at bcd_in[3:0]).
- BIN_W, 8, result width; also the number of shift iterations.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request conversion of bcd_in; sampled only in IDLE or DONE.
- bcd_in  input  4*DIGITS  packed BCD operand, digit d at [4d+3:4d].
- busy  output  1  high while a conversion is in progress (SHIFT state).
- done  output  1  one-cycle pulse; bin_out, ovf and bad_digit are valid from this cycle.
- bin_out  output  BIN_W  binary result; holds until the next done.
- ovf  output  1  decimal value ≥ 2^BIN_W; valid with done, held with bin_out.
- bad_digit  output  1  some input digit > 9 (BCD_CHECK_EN only; otherwise tied 0).

Behaviour:
- Reset values: clk/rst as decided (single clock, rst synchronous active-high). rst forces state IDLE; busy, done, ovf and bad_digit = 0; bin_out = 0; internal registers cleared.
- Internal work register is {bcd_r[4*DIGITS-1:0], bin_r[BIN_W-1:0]}. Iteration counter width is clog2(BIN_W+1).
- IDLE:
  - start=1 → load bcd_r=bcd_in, bin_r=0, cnt=0, then go to SHIFT.
  - start=0 → stay in IDLE.
- SHIFT, one iteration per cycle:
  - Shift the whole work register right by 1.
  - Then, for each digit of bcd_r independently: if the post-shift digit ≥ 8, subtract 3 (4-bit, no borrow between digits).
  - cnt++. After the BIN_W-th iteration, go to DONE.
- DONE, one cycle:
  - done=1.
  - If residual bcd_r ≠ 0, set ovf=1 and bin_out = all ones (saturate). Otherwise ovf=0 and bin_out = bin_r.
  - start=1 in DONE → reload and enter SHIFT (back-to-back). Otherwise go to IDLE.
- Latency: start sampled on edge N → done high in the cycle after edge N+BIN_W (BIN_W+1 cycles, 9 at the default).
- start while busy is ignored and not queued. bcd_in is only sampled at the load edge, so it may change afterwards.
- Registered outputs hold their last result in IDLE. Only done is pulsed.
- Invalid digits without BCD_CHECK_EN: processed by the algorithm unchanged. The result is deterministic but unspecified; the bench must not check it.
- Reset in mid-conversion: abort immediately, no done pulse, outputs return to their reset values.
- rst and start in the same cycle: rst wins.

Optional Feature:
- Macro: BCD_CHECK_EN.
- When defined:
  - At the load edge, flag any digit > 9 into a bad register.
  - In DONE, bad_digit = that flag. If the flag is set, bin_out = 0 and ovf = 0, overriding saturation.
- When undefined: bad_digit is constant 0 and no comparators are built.

Decomposition:
- Package bcd_pkg holds:
  - the state encoding (IDLE, SHIFT, DONE);
  - digit constants DIGIT_MAX=4'd9, ADJ_THRESH=4'd8, ADJ_VAL=4'd3;
  - the counter-width function.
- One sub-module, bcd_digit_adj: combinational 4-bit "≥8 → −3" cell, instantiated DIGITS times with a generate loop.

Test Plan:
- bcd_in=12'h000, pulse start → 9 cycles later done=1, bin_out=8'h00, ovf=0; busy high for exactly 8 cycles.
- bcd_in=12'h255 → bin_out=8'hFF, ovf=0.
- bcd_in=12'h256 → ovf=1, bin_out=8'hFF (saturated).
- Conversion of 12'h128, with start pulsed again using 12'h099 on its 3rd busy cycle → a single done, bin_out=8'h80; the second request is ignored.
- bcd_in=12'h042 with start held in the DONE cycle of 12'h128 → done pulses are 9 cycles apart, second bin_out=8'h2A.
- rst on the 4th busy cycle of 12'h200 → next cycle busy=0, bin_out=0, no done ever; under BCD_CHECK_EN, 12'h1A3 → done with bad_digit=1, bin_out=0, ovf=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared encodings and digit constants for the BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_VAL    = 4'd3;

    // Counter must hold 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: a post-shift digit of 8 or more loses 3.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adj_c
);

    assign adj_c = (digit >= ADJ_THRESH) ? (digit - ADJ_VAL) : digit;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (shift right, subtract 3 from digits >= 8).
// Define BCD_CHECK_EN to flag and zero results for operands holding a digit > 9.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  ovf,
    output logic                  bad_digit
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned WORK_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W  = cnt_width(BIN_W);

    state_t             state, state_n;
    logic [BCD_W-1:0]   bcd_r, bcd_n, bcd_adj_c;
    logic [BIN_W-1:0]   bin_r, bin_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               busy_n, done_n, ovf_n;
    logic [BIN_W-1:0]   bin_out_n;
    logic [WORK_W-1:0]  work_sh_c;

`ifdef BCD_CHECK_EN
    logic bad_r, bad_n, bad_digit_n, bad_in_c;

    // Any operand digit above 9 marks the whole conversion invalid.
    always_comb begin
        bad_in_c = 1'b0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (bcd_in[4*d +: 4] > DIGIT_MAX) begin
                bad_in_c = 1'b1;
            end
        end
    end
`endif

    assign work_sh_c = {bcd_r, bin_r} >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (work_sh_c[BIN_W + 4*g +: 4]),
            .adj_c (bcd_adj_c[4*g +: 4])
        );
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        bcd_n     = bcd_r;
        bin_n     = bin_r;
        cnt_n     = cnt;
        busy_n    = busy;
        done_n    = 1'b0;
        bin_out_n = bin_out;
        ovf_n     = ovf;
`ifdef BCD_CHECK_EN
        bad_n       = bad_r;
        bad_digit_n = bad_digit;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = SHIFT;
                    bcd_n   = bcd_in;
                    bin_n   = '0;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
`ifdef BCD_CHECK_EN
                    bad_n   = bad_in_c;
`endif
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                bcd_n = bcd_adj_c;
                bin_n = work_sh_c[BIN_W-1:0];
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    // Residual decimal digits mean the value did not fit in BIN_W bits.
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    if (|bcd_adj_c) begin
                        ovf_n     = 1'b1;
                        bin_out_n = '1;
                    end else begin
                        ovf_n     = 1'b0;
                        bin_out_n = bin_n;
                    end
`ifdef BCD_CHECK_EN
                    bad_digit_n = bad_r;
                    if (bad_r) begin
                        ovf_n     = 1'b0;
                        bin_out_n = '0;
                    end
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bcd_r   <= '0;
            bin_r   <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_n;
            bcd_r   <= bcd_n;
            bin_r   <= bin_n;
            cnt     <= cnt_n;
            busy    <= busy_n;
            done    <= done_n;
            bin_out <= bin_out_n;
            ovf     <= ovf_n;
        end
    end

`ifdef BCD_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bad_r     <= 1'b0;
            bad_digit <= 1'b0;
        end else begin
            bad_r     <= bad_n;
            bad_digit <= bad_digit_n;
        end
    end
`else
    assign bad_digit = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Bench for bcd_to_bin: cycle-level arithmetic reference plus directed cases.
// Exercises the invalid-digit path only when BCD_CHECK_EN is defined.
module tb_bcd_to_bin;

    localparam int unsigned DIGITS = 3;
    localparam int unsigned BIN_W  = 8;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [11:0] bcd_in;
    logic        busy, done, ovf, bad_digit;
    logic [7:0]  bin_out;

    int total = 0;
    int bad   = 0;

    bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bcd_in    (bcd_in),
        .busy      (busy),
        .done      (done),
        .bin_out   (bin_out),
        .ovf       (ovf),
        .bad_digit (bad_digit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result as {bad, ovf, bin} from the decimal value of the operand.
    function automatic logic [9:0] model_conv(input logic [11:0] b);
        int v       = 0;
        bit invalid = 1'b0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            int dig = int'(b[4*d +: 4]);
            if (dig > 9) invalid = 1'b1;
            v = v * 10 + dig;
        end
`ifdef BCD_CHECK_EN
        if (invalid) return {1'b1, 1'b0, 8'h00};
`endif
        if (v >= (1 << BIN_W)) return {1'b0, 1'b1, 8'hFF};
        return {1'b0, 1'b0, v[7:0]};
    endfunction

    // Reference: a request accepted while idle completes BIN_W+1 cycles later.
    int         m_left  = 0;
    bit         m_valid = 1'b0;
    bit         m_done  = 1'b0;
    logic [9:0] m_pend  = '0;
    logic [9:0] m_res   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_left  = 0;
            m_done  = 1'b0;
            m_res   = '0;
            m_valid = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_res  = m_pend;
                end
            end else if (start) begin
                m_left = BIN_W;
                m_pend = model_conv(bcd_in);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_busy", int'(busy), int'(m_left > 0));
            check("cyc_done", int'(done), int'(m_done));
            check("cyc_bin_out", int'(bin_out), int'(m_res[7:0]));
            check("cyc_ovf", int'(ovf), int'(m_res[8]));
            check("cyc_bad_digit", int'(bad_digit), int'(m_res[9]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input logic [11:0] v);
        start  = 1'b1;
        bcd_in = v;
        tick();
        start  = 1'b0;
    endtask

    // Waits (bounded) for done; returns cycles waited and busy cycles seen.
    task automatic run_wait(input string name, output int lat, output int bcnt);
        bit found = 1'b0;
        lat  = 0;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, int'(found), 1);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    function automatic logic [11:0] rand_bcd();
        logic [11:0] b;
        for (int d = 0; d < DIGITS; d++) begin
            b[4*d +: 4] = 4'($urandom_range(0, 9));
`ifdef BCD_CHECK_EN
            if ($urandom_range(0, 15) == 0) b[4*d +: 4] = 4'($urandom_range(10, 15));
`endif
        end
        return b;
    endfunction

    initial begin
        int lat, bcnt, n;
        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = '0;
        repeat (3) tick();
        rst = 1'b0;

        check("model_256", int'(model_conv(12'h256)), 10'h1FF);
        check("model_255", int'(model_conv(12'h255)), 10'h0FF);
        check("model_042", int'(model_conv(12'h042)), 10'h02A);

        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_bin_out", int'(bin_out), 0);
        check("rst_ovf", int'(ovf), 0);
        tick();

        convert(12'h000);
        run_wait("zero", lat, bcnt);
        check("zero_latency", lat, 9);
        check("zero_busy_cycles", bcnt, 8);
        check("zero_bin_out", int'(bin_out), 8'h00);
        check("zero_ovf", int'(ovf), 0);
        tick();

        convert(12'h255);
        run_wait("max", lat, bcnt);
        check("max_bin_out", int'(bin_out), 8'hFF);
        check("max_ovf", int'(ovf), 0);
        tick();

        convert(12'h256);
        run_wait("sat", lat, bcnt);
        check("sat_bin_out", int'(bin_out), 8'hFF);
        check("sat_ovf", int'(ovf), 1);
        tick();

        convert(12'h128);
        tick();
        tick();
        start  = 1'b1;
        bcd_in = 12'h099;
        tick();
        start  = 1'b0;
        run_wait("ign", lat, bcnt);
        check("ign_bin_out", int'(bin_out), 8'h80);
        check("ign_ovf", int'(ovf), 0);
        count_dones(12, n);
        check("ign_extra_done", n, 0);
        tick();

        convert(12'h128);
        run_wait("b2b_first", lat, bcnt);
        check("b2b_first_bin_out", int'(bin_out), 8'h80);
        start  = 1'b1;
        bcd_in = 12'h042;
        @(posedge clk);
        #1;
        start  = 1'b0;
        run_wait("b2b_second", lat, bcnt);
        check("b2b_spacing", lat, 9);
        check("b2b_second_bin_out", int'(bin_out), 8'h2A);
        tick();

        convert(12'h200);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_bin_out", int'(bin_out), 0);
        check("abort_ovf", int'(ovf), 0);
        count_dones(15, n);
        check("abort_no_done", n, 0);
        tick();

`ifdef BCD_CHECK_EN
        convert(12'h256);
        run_wait("pre_bad", lat, bcnt);
        tick();
        convert(12'h1A3);
        run_wait("bad", lat, bcnt);
        check("bad_flag", int'(bad_digit), 1);
        check("bad_bin_out", int'(bin_out), 0);
        check("bad_ovf", int'(ovf), 0);
        tick();
`endif

        for (int i = 0; i < 3000; i++) begin
            start  = ($urandom_range(0, 2) == 0);
            bcd_in = rand_bcd();
            rst    = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (12) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
